// File: rtl/instr_decode_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_decode_stage_if
// Description : Fetch-side handshake plus decoded-bundle signals of the decode stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_decode_stage_if #(
  parameter int XLEN = 32,
  parameter int PC_W = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [6:0]      opcode;
  logic [4:0]      rd;
  logic [2:0]      funct3;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm;
  logic [2:0]      fmt;
  logic            illegal;
  logic [PC_W-1:0] out_pc;

  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, opcode, rd, funct3, rs1, rs2, funct7,
           imm, fmt, illegal, out_pc
  );

  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, opcode, rd, funct3, rs1, rs2, funct7,
           imm, fmt, illegal, out_pc
  );
endinterface
`default_nettype wire

// File: rtl/instr_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : instr_decode_stage
// Description : Registered RV32I/RV64I decode: field split, immediate, format.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_decode_stage #(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  instr_decode_stage_if.slave bus
);

  localparam logic [2:0] c_fmt_r   = 3'd0;
  localparam logic [2:0] c_fmt_i   = 3'd1;
  localparam logic [2:0] c_fmt_s   = 3'd2;
  localparam logic [2:0] c_fmt_b   = 3'd3;
  localparam logic [2:0] c_fmt_u   = 3'd4;
  localparam logic [2:0] c_fmt_j   = 3'd5;
  localparam logic [2:0] c_fmt_bad = 3'd7;

  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_imm    = 7'b0010011;
  localparam logic [6:0] c_op_jalr   = 7'b1100111;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_lui    = 7'b0110111;
  localparam logic [6:0] c_op_auipc  = 7'b0010111;
  localparam logic [6:0] c_op_jal    = 7'b1101111;
  localparam logic [6:0] c_op_op     = 7'b0110011;

  logic [31:0]     w_instr;
  logic [2:0]      w_fmt;
  logic            w_illegal;
  logic [31:0]     w_imm32;
  logic [XLEN-1:0] w_imm;
  logic            w_in_ready;
  logic            w_in_fire;

  logic            r_valid;
  logic [31:0]     r_instr;
  logic [XLEN-1:0] r_imm;
  logic [2:0]      r_fmt;
  logic            r_illegal;
  logic [PC_W-1:0] r_pc;

  assign w_instr = bus.in_instr;

  // Immediates are built at 32 bits first; the widening to XLEN is a pure
  // replication of bit 31 done below.
  always_comb begin
    w_fmt     = c_fmt_bad;
    w_illegal = 1'b1;
    w_imm32   = '0;
    if (w_instr[1:0] == 2'b11) begin
      w_illegal = 1'b0;
      case (w_instr[6:0])
        c_op_load, c_op_imm, c_op_jalr: begin
          w_fmt   = c_fmt_i;
          w_imm32 = {{20{w_instr[31]}}, w_instr[31:20]};
        end
        c_op_store: begin
          w_fmt   = c_fmt_s;
          w_imm32 = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
        end
        c_op_branch: begin
          w_fmt   = c_fmt_b;
          w_imm32 = {{19{w_instr[31]}}, w_instr[31], w_instr[7],
                     w_instr[30:25], w_instr[11:8], 1'b0};
        end
        c_op_lui, c_op_auipc: begin
          w_fmt   = c_fmt_u;
          w_imm32 = {w_instr[31:12], 12'b0};
        end
        c_op_jal: begin
          w_fmt   = c_fmt_j;
          w_imm32 = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12],
                     w_instr[20], w_instr[30:21], 1'b0};
        end
        c_op_op: begin
          w_fmt = c_fmt_r;
        end
        default: begin
          w_fmt     = c_fmt_bad;
          w_illegal = 1'b1;
        end
      endcase
    end
  end

  generate
    if (XLEN > 32) begin : g_imm_wide
      assign w_imm = {{(XLEN-32){w_imm32[31]}}, w_imm32};
    end else begin : g_imm_narrow
      assign w_imm = w_imm32[XLEN-1:0];
    end
  endgenerate

  // Flush makes the stage ready so a concurrent fetch is swallowed, not stalled.
  assign w_in_ready = !r_valid | bus.out_ready | bus.flush;
  assign w_in_fire  = bus.in_valid & w_in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid   <= 1'b0;
      r_instr   <= '0;
      r_imm     <= '0;
      r_fmt     <= '0;
      r_illegal <= 1'b0;
      r_pc      <= '0;
    end else if (bus.flush) begin
      r_valid <= 1'b0;
    end else if (w_in_fire) begin
      r_valid   <= 1'b1;
      r_instr   <= w_instr;
      r_imm     <= w_imm;
      r_fmt     <= w_fmt;
      r_illegal <= w_illegal;
      r_pc      <= bus.in_pc;
    end else if (bus.out_ready) begin
      r_valid <= 1'b0;
    end
  end

  // Raw fields are fixed slices of the held word, independent of format.
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_valid;
  assign bus.opcode    = r_instr[6:0];
  assign bus.rd        = r_instr[11:7];
  assign bus.funct3    = r_instr[14:12];
  assign bus.rs1       = r_instr[19:15];
  assign bus.rs2       = r_instr[24:20];
  assign bus.funct7    = r_instr[31:25];
  assign bus.imm       = r_imm;
  assign bus.fmt       = r_fmt;
  assign bus.illegal   = r_illegal;
  assign bus.out_pc    = r_pc;

endmodule
`default_nettype wire
